// File: rtl/mudi_ctrl_if.sv
// Purpose : handshake/data bundle between the EX stage and the HI/LO mult/div scheduler.
// Latency : n/a (wires only).
// Backpressure: op_ready/busy flow from the scheduler back to EX; flush aborts from EX.
//
// Ports (signals carried):
//   op_valid  EX -> ctrl   op request
//   op_mudi   EX -> ctrl   one-hot op code: [0]mult [1]multu [2]div [3]divu
//   op_src1   EX -> ctrl   rs value (multiplicand / dividend)
//   op_src2   EX -> ctrl   rt value (multiplier / divisor)
//   flush     EX -> ctrl   abort the in-flight op, no HI/LO write
//   op_ready  ctrl -> EX   scheduler idle, can accept
//   busy      ctrl -> EX   stall request while an op is in flight
//   hl_we     ctrl -> EX   one-cycle HI/LO write strobe
//   hi_wdata  ctrl -> EX   product high half or remainder
//   lo_wdata  ctrl -> EX   product low half or quotient
interface mudi_ctrl_if #(
    parameter int XLEN = 32
);
    logic            op_valid;
    logic [3:0]      op_mudi;
    logic [XLEN-1:0] op_src1;
    logic [XLEN-1:0] op_src2;
    logic            flush;
    logic            op_ready;
    logic            busy;
    logic            hl_we;
    logic [XLEN-1:0] hi_wdata;
    logic [XLEN-1:0] lo_wdata;

    // EX-stage side
    modport master (
        output op_valid, op_mudi, op_src1, op_src2, flush,
        input  op_ready, busy, hl_we, hi_wdata, lo_wdata
    );

    // Scheduler side
    modport slave (
        input  op_valid, op_mudi, op_src1, op_src2, flush,
        output op_ready, busy, hl_we, hi_wdata, lo_wdata
    );
endinterface

// File: rtl/mudi_ctrl.sv
// Purpose : iterative HI/LO scheduler for mult/multu (shift-add) and div/divu (restoring).
// Latency : XLEN+1 cycles from accept to the hl_we cycle (1 cycle for mult/multu with MUDI_FAST_MUL_EN).
// Backpressure: op_ready=0 / busy=1 while an op is in flight; flush aborts it with no HI/LO write.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   bus    mudi_ctrl_if.slave  (op_valid/op_mudi/op_src1/op_src2/flush in;
//                               op_ready/busy/hl_we/hi_wdata/lo_wdata out)
//
// Build option:
//   MUDI_FAST_MUL_EN  when defined, mult/multu complete with a single-cycle
//                     XLEN x XLEN multiply (IDLE -> DONE on accept). Divides
//                     always use the iterative path.
//
// Parameters:
//   XLEN   operand width (even, >= 8); one iteration per operand bit
//   CNT_W  iteration counter width; 2**CNT_W must exceed XLEN
module mudi_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    mudi_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_opnd;     // multiplicand magnitude, or divisor magnitude
    logic [XLEN-1:0]   r_hi;       // partial product high half, or partial remainder
    logic [XLEN-1:0]   r_lo;       // multiplier (shifting out) / dividend->quotient
    logic              r_s1;       // src1 negative (signed ops only)
    logic              r_s2;       // src2 negative (signed ops only)
    logic              r_is_div;
    logic [XLEN-1:0]   r_hi_wdata;
    logic [XLEN-1:0]   r_lo_wdata;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic              w_onehot;
    logic              w_accept;
    logic              w_is_mul_in;
    logic              w_signed_in;
    logic              w_s1_in;
    logic              w_s2_in;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_last;

    // A zero code or more than one set bit is simply ignored.
    assign w_onehot    = (bus.op_mudi != 4'b0000) &&
                         ((bus.op_mudi & (bus.op_mudi - 4'd1)) == 4'b0000);
    // Flush wins over a simultaneous request.
    assign w_accept    = bus.op_valid && (r_state == S_IDLE) && !bus.flush && w_onehot;
    assign w_is_mul_in = bus.op_mudi[0] | bus.op_mudi[1];
    assign w_signed_in = bus.op_mudi[0] | bus.op_mudi[2];
    assign w_s1_in     = w_signed_in & bus.op_src1[XLEN-1];
    assign w_s2_in     = w_signed_in & bus.op_src2[XLEN-1];
    // Two's-complement negate of the most negative value yields itself,
    // which read unsigned is the correct magnitude.
    assign w_mag1      = w_s1_in ? (-bus.op_src1) : bus.op_src1;
    assign w_mag2      = w_s2_in ? (-bus.op_src2) : bus.op_src2;
    assign w_last      = (r_cnt == CNT_W'(XLEN - 1));

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN-1:0]   w_mul_hi_nxt;
    logic [XLEN-1:0]   w_mul_lo_nxt;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_hi_nxt;
    logic [XLEN-1:0]   w_div_lo_nxt;
    logic [XLEN-1:0]   w_hi_nxt;
    logic [XLEN-1:0]   w_lo_nxt;

    // Shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole {carry, hi, lo} right by one. The
    // multiplier bits drain out of lo while product bits fill in from the top.
    assign w_mul_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_mul_hi_nxt = w_mul_sum[XLEN:1];
    assign w_mul_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder, try
    // subtracting the divisor, keep the difference only if it did not borrow.
    assign w_div_shift  = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff   = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge     = ~w_div_diff[XLEN];
    assign w_div_hi_nxt = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    assign w_div_lo_nxt = {r_lo[XLEN-2:0], w_div_ge};

    assign w_hi_nxt     = r_is_div ? w_div_hi_nxt : w_mul_hi_nxt;
    assign w_lo_nxt     = r_is_div ? w_div_lo_nxt : w_mul_lo_nxt;

    // ------------------------------------------------------------------
    // Final sign fix-up, applied to the result of the last iteration
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_signed;
    logic [XLEN-1:0]   w_res_hi;
    logic [XLEN-1:0]   w_res_lo;

    assign w_prod        = {w_hi_nxt, w_lo_nxt};
    assign w_prod_signed = (r_s1 ^ r_s2) ? (-w_prod) : w_prod;

    always_comb begin
        w_res_hi = w_prod_signed[2*XLEN-1:XLEN];
        w_res_lo = w_prod_signed[XLEN-1:0];
        if (r_is_div) begin
            // Remainder takes the dividend's sign (truncating division).
            w_res_hi = r_s1 ? (-w_hi_nxt) : w_hi_nxt;
            if (r_opnd == '0) begin
                // With a zero divisor every trial subtract succeeds, so the
                // remainder path simply shifts the dividend magnitude in; after
                // the sign fix-up above HI is the raw src1. LO is forced to
                // all ones regardless of the operand signs.
                w_res_lo = '1;
            end else begin
                w_res_lo = (r_s1 ^ r_s2) ? (-w_lo_nxt) : w_lo_nxt;
            end
        end
    end

`ifdef MUDI_FAST_MUL_EN
    // ------------------------------------------------------------------
    // Single-cycle multiply on the request operands
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_fast_prod;
    logic [2*XLEN-1:0] w_fast_res;

    assign w_fast_prod = w_mag1 * w_mag2;
    assign w_fast_res  = (w_s1_in ^ w_s2_in) ? (-w_fast_prod) : w_fast_prod;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and status outputs
    // ------------------------------------------------------------------
    logic w_op_ready;
    logic w_busy;
    logic w_hl_we;

    always_comb begin
        w_state_nxt = r_state;
        w_op_ready  = 1'b0;
        w_busy      = 1'b1;
        w_hl_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_op_ready = 1'b1;
                w_busy     = 1'b0;
                if (w_accept) begin
`ifdef MUDI_FAST_MUL_EN
                    w_state_nxt = w_is_mul_in ? S_DONE : S_CALC;
`else
                    w_state_nxt = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A flush landing in the write cycle cancels the write.
                w_hl_we     = ~bus.flush;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign bus.op_ready = w_op_ready;
    assign bus.busy     = w_busy;
    assign bus.hl_we    = w_hl_we;
    assign bus.hi_wdata = r_hi_wdata;
    assign bus.lo_wdata = r_lo_wdata;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_is_div   <= 1'b0;
            r_hi_wdata <= '0;
            r_lo_wdata <= '0;
        end else if (w_accept) begin
            // Operands are captured only here; later port changes are ignored.
            r_cnt    <= '0;
            r_s1     <= w_s1_in;
            r_s2     <= w_s2_in;
            r_is_div <= ~w_is_mul_in;
            r_hi     <= '0;
            if (w_is_mul_in) begin
                r_opnd <= w_mag1;
                r_lo   <= w_mag2;
            end else begin
                r_opnd <= w_mag2;
                r_lo   <= w_mag1;
            end
`ifdef MUDI_FAST_MUL_EN
            if (w_is_mul_in) begin
                r_hi_wdata <= w_fast_res[2*XLEN-1:XLEN];
                r_lo_wdata <= w_fast_res[XLEN-1:0];
            end
`endif
        end else if ((r_state == S_CALC) && !bus.flush) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            // Write data only changes when an op actually completes, so an
            // aborted op leaves the previous HI/LO values on the outputs.
            if (w_last) begin
                r_hi_wdata <= w_res_hi;
                r_lo_wdata <= w_res_lo;
            end
        end
    end

endmodule

// File: tb/tb_mudi_ctrl.sv
// Bench for mudi_ctrl: a driver issues ops and queues the expected HI/LO
// values with the cycle the write strobe should appear in; a monitor pops
// and compares on every hl_we pulse.
module tb_mudi_ctrl;
    localparam int X = 32;
`ifdef MUDI_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [X-1:0] q_hi[$];
    logic [X-1:0] q_lo[$];
    int           q_cyc[$];

    mudi_ctrl_if #(.XLEN(X)) bus();

    mudi_ctrl #(.XLEN(X), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]   m;
        logic [X-1:0] a;
        logic [X-1:0] b;
        logic [X-1:0] hi;
        logic [X-1:0] lo;
    } vec_t;

    // Directed vectors with hand-computed results.
    vec_t tbl [10] = '{
        '{4'b0100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD}, // div -7/2
        '{4'b0100, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD}, // div 7/-2
        '{4'b0100, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF}, // div x/0
        '{4'b0100, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF}, // div -5/0
        '{4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000}, // overflow
        '{4'b1000, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF}, // divu
        '{4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001}, // multu max
        '{4'b0001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000}, // mult min^2
        '{4'b0001, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6}, // mult 7*-6
        '{4'b1000, 32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000}  // divu 5/9
    };

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        logic [X-1:0] eh;
        logic [X-1:0] el;
        int           ec;
        if (!reset && bus.hl_we) begin
            n_vec++;
            if (q_hi.size() == 0) begin
                n_err++;
                $display("FAIL hl_we_unexpected: pulse at cycle %0d HI=%h LO=%h, want no pulse",
                         cyc, bus.hi_wdata, bus.lo_wdata);
            end else begin
                eh = q_hi.pop_front();
                el = q_lo.pop_front();
                ec = q_cyc.pop_front();
                if (bus.hi_wdata !== eh || bus.lo_wdata !== el || cyc != ec) begin
                    n_err++;
                    $display("FAIL hl_we_result: got HI=%h LO=%h cyc=%0d, want HI=%h LO=%h cyc=%0d",
                             bus.hi_wdata, bus.lo_wdata, cyc, eh, el, ec);
                end
            end
        end
    end

    // Drive one request for one cycle; call #1 after a rising edge.
    task automatic issue(input logic [3:0] m, input logic [X-1:0] a, input logic [X-1:0] b,
                         input bit push, input logic [X-1:0] ehi, input logic [X-1:0] elo);
        int lat;
        lat = (FAST && (m[0] || m[1])) ? 1 : X + 1;
        bus.op_valid = 1'b1;
        bus.op_mudi  = m;
        bus.op_src1  = a;
        bus.op_src2  = b;
        if (push) begin
            q_hi.push_back(ehi);
            q_lo.push_back(elo);
            q_cyc.push_back(cyc + lat);
        end
        @(posedge clk); #1;
        // Scramble operands after accept: the DUT must not look at them.
        bus.op_valid = 1'b0;
        bus.op_mudi  = 4'b1111;
        bus.op_src1  = 32'hDEADBEEF;
        bus.op_src2  = 32'h0BADF00D;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (!bus.busy) done = 1'b1;
        end
        chk({name, "_idle"}, 64'(done), 64'd1);
    endtask

    initial begin
        logic [X-1:0] last_hi;
        logic [X-1:0] last_lo;
        reset        = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_mudi  = 4'b0000;
        bus.op_src1  = '0;
        bus.op_src2  = '0;
        bus.flush    = 1'b0;
        #3;
        chk("rst_ready", 64'(bus.op_ready), 64'd1);
        chk("rst_busy",  64'(bus.busy),     64'd0);
        chk("rst_hl_we", 64'(bus.hl_we),    64'd0);
        chk("rst_hi",    64'(bus.hi_wdata), 64'd0);
        chk("rst_lo",    64'(bus.lo_wdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // mult -3 * 5
        issue(4'b0001, 32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
        wait_idle("mult_neg");

        // divu 100/7 with busy/op_ready tracked every cycle
        issue(4'b1000, 32'd100, 32'd7, 1'b1, 32'h00000002, 32'h0000000E);
        for (int i = 1; i <= X + 1; i++) begin
            chk("divu_busy",  64'(bus.busy),     64'd1);
            chk("divu_ready", 64'(bus.op_ready), 64'd0);
            @(posedge clk); #1;
        end
        chk("divu_done_busy",  64'(bus.busy),     64'd0);
        chk("divu_done_ready", 64'(bus.op_ready), 64'd1);

        // Table, each issued in the first idle cycle after the previous op
        last_hi = '0;
        last_lo = '0;
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].m, tbl[i].a, tbl[i].b, 1'b1, tbl[i].hi, tbl[i].lo);
            wait_idle("tbl");
            last_hi = tbl[i].hi;
            last_lo = tbl[i].lo;
        end

        // Flush in busy cycle 10: idle at 11, outputs unchanged, new op accepted at 11
        issue(4'b1000, 32'h55555555, 32'h00000003, 1'b0, '0, '0);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy",  64'(bus.busy),     64'd0);
        chk("flush_ready", 64'(bus.op_ready), 64'd1);
        chk("flush_hi",    64'(bus.hi_wdata), 64'(last_hi));
        chk("flush_lo",    64'(bus.lo_wdata), 64'(last_lo));
        issue(4'b0001, 32'd3, 32'd4, 1'b1, 32'h00000000, 32'h0000000C);
        wait_idle("after_flush");

        // Flush together with a valid request: no accept
        bus.op_valid = 1'b1; bus.op_mudi = 4'b0001; bus.flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_vs_accept_busy", 64'(bus.busy), 64'd0);
        bus.flush = 1'b0;

        // Non-one-hot codes are ignored
        bus.op_mudi = 4'b0011;
        @(posedge clk); #1;
        chk("mudi_0011_busy",  64'(bus.busy),     64'd0);
        chk("mudi_0011_ready", 64'(bus.op_ready), 64'd1);
        bus.op_mudi = 4'b0000;
        @(posedge clk); #1;
        chk("mudi_0000_busy",  64'(bus.busy),     64'd0);
        bus.op_valid = 1'b0;

        // Flush in the write cycle suppresses hl_we
        issue(4'b1000, 32'd9, 32'd3, 1'b0, '0, '0);
        repeat (X) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        #1;
        chk("flush_done_busy",  64'(bus.busy),  64'd1);
        chk("flush_done_hl_we", 64'(bus.hl_we), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_done_idle", 64'(bus.busy), 64'd0);

        // Async reset in busy cycle 5: outputs return to reset values at once
        issue(4'b1000, 32'd50, 32'd5, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ready", 64'(bus.op_ready), 64'd1);
        chk("arst_busy",  64'(bus.busy),     64'd0);
        chk("arst_hl_we", 64'(bus.hl_we),    64'd0);
        chk("arst_hi",    64'(bus.hi_wdata), 64'd0);
        chk("arst_lo",    64'(bus.lo_wdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (X + 8) @(posedge clk);
        #1;
        chk("arst_stays_idle", 64'(bus.busy), 64'd0);
        chk("queue_drained", 64'(q_hi.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
